// File: rtl/trojan_mon_pkg.sv
// trojan_mon_pkg: shared state encoding and default parameters for the node monitor
package trojan_mon_pkg;
  typedef enum logic [1:0] {IDLE, FLUSH, RUN, DONE} mon_state_t;
  localparam int WIN_LEN_DEF  = 256;
  localparam int LAT_DEF      = 3;
  localparam int RARE_THR_DEF = 4;
endpackage

// File: rtl/rare_node_monitor_golden_delay.sv
// golden_delay: LAT-deep shift register aligning the golden stream with the subcircuit output
module golden_delay #(
  parameter int LAT = 3
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);
  logic [LAT-1:0] sr_q;
  always_ff @(posedge clk_i)
    if (!rst_n_i) sr_q <= '0;
    else sr_q <= (sr_q << 1) | LAT'(d_i);
  assign q_o = sr_q[LAT-1];
endmodule

// File: rtl/rare_node_monitor.sv
// rare_node_monitor: windowed ones/toggle/golden-mismatch counting with rare and mismatch flags
module rare_node_monitor
  import trojan_mon_pkg::*;
#(
  parameter int WIN_LEN  = WIN_LEN_DEF,
  parameter int LAT      = LAT_DEF,
  parameter int RARE_THR = RARE_THR_DEF,
  localparam int CNT_W   = $clog2(WIN_LEN + 1)
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic             start,
  input  logic             node_in,
  input  logic             golden_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             rare_flag,
  output logic             mismatch_flag
);
  localparam int FL_W = $clog2(LAT + 1);
  mon_state_t       state_q;
  logic [FL_W-1:0]  flush_q;
  logic [CNT_W-1:0] ones_q, tog_q, mis_q, samp_q;
  logic [CNT_W-1:0] ones_d, tog_d, mis_d;
  logic             prev_q, rare_q, misf_q, golden_d, last_d;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic b);
    return (b && c != CNT_W'(WIN_LEN)) ? c + 1'b1 : c;
  endfunction
  golden_delay #(.LAT(LAT)) u_golden_delay (
    .clk_i  (I1470_clk),
    .rst_n_i(I1477_rst),
    .d_i    (golden_in),
    .q_o    (golden_d)
  );
  always_comb begin
    ones_d = sat_inc(ones_q, node_in);
    mis_d  = sat_inc(mis_q, node_in ^ golden_d);
    tog_d  = (samp_q == '0) ? tog_q : sat_inc(tog_q, node_in ^ prev_q);
    last_d = samp_q == CNT_W'(WIN_LEN - 1);
  end
  always_ff @(posedge I1470_clk)
    if (!I1477_rst) begin
      state_q <= IDLE;
      flush_q <= '0;
      ones_q  <= '0;
      tog_q   <= '0;
      mis_q   <= '0;
      samp_q  <= '0;
      prev_q  <= 1'b0;
      rare_q  <= 1'b0;
      misf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= FLUSH;
          flush_q <= FL_W'(LAT);
          ones_q  <= '0;
          tog_q   <= '0;
          mis_q   <= '0;
          samp_q  <= '0;
          prev_q  <= 1'b0;
          rare_q  <= 1'b0;
          misf_q  <= 1'b0;
        end
        FLUSH: begin
          flush_q <= flush_q - 1'b1;
          if (flush_q == FL_W'(1)) state_q <= RUN;
        end
        RUN: begin
          ones_q <= ones_d;
          tog_q  <= tog_d;
          mis_q  <= mis_d;
          prev_q <= node_in;
          samp_q <= samp_q + 1'b1;
          // flags use the post-sample counts so the final sample is included
          if (last_d) begin
            state_q <= DONE;
            rare_q  <= ones_d < CNT_W'(RARE_THR) || ones_d > CNT_W'(WIN_LEN - RARE_THR);
            misf_q  <= mis_d != '0;
          end
        end
      endcase
    end
  assign busy          = state_q == FLUSH || state_q == RUN;
  assign done          = state_q == DONE;
  assign ones_cnt      = ones_q;
  assign toggle_cnt    = tog_q;
  assign mismatch_cnt  = mis_q;
  assign rare_flag     = rare_q;
  assign mismatch_flag = misf_q;
endmodule

// File: tb/tb_rare_node_monitor.sv
// tb_rare_node_monitor: directed checks of window counting, flags, start and reset handling
module tb_rare_node_monitor;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, node_in = 1'b0, golden_in = 1'b0;
  logic       busy, done, rare_flag, mismatch_flag;
  logic [4:0] ones_cnt, toggle_cnt, mismatch_cnt;
  int         total = 0, bad = 0;
  rare_node_monitor #(.WIN_LEN(16), .LAT(3), .RARE_THR(2)) dut (
    .I1470_clk    (clk),
    .I1477_rst    (rst),
    .start        (start),
    .node_in      (node_in),
    .golden_in    (golden_in),
    .busy         (busy),
    .done         (done),
    .ones_cnt     (ones_cnt),
    .toggle_cnt   (toggle_cnt),
    .mismatch_cnt (mismatch_cnt),
    .rare_flag    (rare_flag),
    .mismatch_flag(mismatch_flag)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_ones"}, ones_cnt, 0);
    check({tag, "_tog"}, toggle_cnt, 0);
    check({tag, "_mis"}, mismatch_cnt, 0);
    check({tag, "_rare"}, rare_flag, 0);
    check({tag, "_misf"}, mismatch_flag, 0);
  endtask
  // edge n counts from the start edge (n=0); RUN samples land on edges 4..19
  task automatic drive(input int mode, input int n, input bit extra_start);
    node_in   = (mode != 0) && ((n % 2 == 1) ^ (mode == 2 && n >= 7 && n <= 11));
    golden_in = (mode != 0) && ((n + 3) % 2 == 1);
    start     = (n == 0) || (extra_start && n == 8);
  endtask
  task automatic meas(input string tag, input int mode, input bit extra_start);
    for (int n = 0; n <= 19; n++) begin
      drive(mode, n, extra_start);
      tick();
      if (n == 0) begin
        check({tag, "_busy0"}, busy, 1);
        check({tag, "_ones0"}, ones_cnt, 0);
        check({tag, "_done0"}, done, 0);
      end
      if (n == 18) check({tag, "_done_early"}, done, 0);
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
  endtask
  task automatic result(input string tag, input int o, input int t, input int m, input int r, input int mf);
    check({tag, "_ones"}, ones_cnt, o);
    check({tag, "_tog"}, toggle_cnt, t);
    check({tag, "_mis"}, mismatch_cnt, m);
    check({tag, "_rare"}, rare_flag, r);
    check({tag, "_misf"}, mismatch_flag, mf);
  endtask
  initial begin
    #1;
    start = 1'b1;
    tick();
    tick();
    outputs_zero("rst");
    start = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check("idle_busy", busy, 0);
    meas("zero", 0, 1'b0);
    result("zero", 0, 0, 0, 1, 0);
    tick();
    check("done_hold", done, 1);
    meas("alt", 1, 1'b0);
    result("alt", 8, 15, 0, 0, 0);
    meas("fault", 2, 1'b0);
    result("fault", 7, 13, 5, 0, 1);
    meas("restart", 1, 1'b1);
    result("restart", 8, 15, 0, 0, 0);
    for (int n = 0; n <= 13; n++) begin
      drive(1, n, 1'b0);
      if (n == 13) rst = 1'b0;
      tick();
      if (n == 12) check("mid_ones", ones_cnt, 4);
    end
    start = 1'b0;
    outputs_zero("midrst");
    rst = 1'b1;
    tick();
    meas("after_rst", 2, 1'b0);
    result("after_rst", 7, 13, 5, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
